// File: rtl/dcpu16_memslv.sv
// Single-port 2^AW x 16 word memory slave for the DCPU-16 bus.
// A programmable number of wait states precedes a one-cycle registered acknowledge.
module dcpu16_memslv #(
    parameter int AW = 10,
    parameter int WS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_adr,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // WAIT runs WS-1 down to 0, so the commit happens WS cycles after the request.
    localparam logic [3:0] WS_LOAD = (WS == 0) ? 4'd0 : 4'(WS - 1);
    localparam logic       NO_WAIT = (WS == 0);

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic [15:0]   f_dti_r;
    logic          f_ack_r;
    logic [15:0]   mem_r [0:(2**AW)-1];

    logic [AW-1:0] addr_s;
    logic          commit_s;
    logic          wr_s;
    logic          unused_adr_s;

    assign unused_adr_s = ^f_adr;

    // Decode whether this cycle's edge enters ACK, i.e. commits the transfer.
    always_comb begin
        addr_s   = f_adr[AW-1:0];
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (f_stb && NO_WAIT) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (f_stb && (cnt_r == 4'd0)) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
        if (ena && !rst && commit_s && f_wre) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Memory array: written only on a committing edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[addr_s] <= f_dto;
        end
    end

    // Transfer FSM with wait counter, registered ack and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            f_ack_r <= 1'b0;
            f_dti_r <= 16'h0000;
        end else if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (commit_s) begin
                        state_r <= ST_ACK;
                        f_ack_r <= 1'b1;
                        if (!f_wre) begin
                            f_dti_r <= mem_r[addr_s];
                        end
                    end else if (f_stb) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= WS_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (!f_stb) begin
                        // Master withdrew the request: abandon without side effects.
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else if (commit_s) begin
                        state_r <= ST_ACK;
                        f_ack_r <= 1'b1;
                        if (!f_wre) begin
                            f_dti_r <= mem_r[addr_s];
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    f_ack_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    f_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign f_dti = f_dti_r;
    assign f_ack = f_ack_r;

endmodule

// File: tb/tb_dcpu16_memslv.sv
// Bench for dcpu16_memslv: four instances with WS = 0, 3, 5, 2 checked
// against a word-array model with directed and random transfers.
module tb_dcpu16_memslv;

    localparam int          N     = 4;
    localparam logic [15:0] WS_PK = {4'd2, 4'd5, 4'd3, 4'd0};

    logic        clk;
    logic        rst   [N];
    logic        ena   [N];
    logic        f_stb [N];
    logic        f_wre [N];
    logic [15:0] f_adr [N];
    logic [15:0] f_dto [N];
    logic [15:0] f_dti [N];
    logic        f_ack [N];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl     [N][1024];
    logic [15:0] last_rd [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        dcpu16_memslv #(.AW(10), .WS(int'(WS_PK[g*4 +: 4]))) u_dut (
            .clk   (clk),
            .rst   (rst[g]),
            .ena   (ena[g]),
            .f_stb (f_stb[g]),
            .f_wre (f_wre[g]),
            .f_adr (f_adr[g]),
            .f_dto (f_dto[g]),
            .f_dti (f_dti[g]),
            .f_ack (f_ack[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int ws_of(input int i);
        logic [15:0] p;
        p = WS_PK;
        return int'(p[i*4 +: 4]);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    // Step edges until ack; optionally drop ena for 'gap' cycles after the first edge.
    task automatic wait_ack(input int i, input int gap, output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gap > 0 && cyc == 1) ena[i] = 1'b0;
            if (gap > 0 && cyc == 1 + gap) ena[i] = 1'b1;
            if (f_ack[i] === 1'b1) break;
            if (cyc >= 60) begin
                chk("ack_timeout", i, 32'(f_ack[i]), 32'd1);
                break;
            end
        end
    endtask

    task automatic xfer(input int i, input logic wre, input logic [15:0] adr,
                        input logic [15:0] dto, input int gap);
        int cyc;
        f_wre[i] = wre;
        f_adr[i] = adr;
        f_dto[i] = dto;
        f_stb[i] = 1'b1;
        wait_ack(i, gap, cyc);
        chk("latency", i, cyc, ws_of(i) + 1 + gap);
        if (wre) begin
            mdl[i][adr[9:0]] = dto;
            chk("wr_dti_hold", i, 32'(f_dti[i]), 32'(last_rd[i]));
        end else begin
            last_rd[i] = mdl[i][adr[9:0]];
            chk("rd_data", i, 32'(f_dti[i]), 32'(last_rd[i]));
        end
        f_stb[i] = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_width", i, 32'(f_ack[i]), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic seen;
        for (int i = 0; i < N; i++) begin
            rst[i]     = 1'b1;
            ena[i]     = 1'b0;
            f_stb[i]   = 1'b0;
            f_wre[i]   = 1'b0;
            f_adr[i]   = 16'h0000;
            f_dto[i]   = 16'h0000;
            last_rd[i] = 16'h0000;
        end
        // Reset must take effect even with ena low.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_ack", i, 32'(f_ack[i]), 32'd0);
            chk("rst_dti", i, 32'(f_dti[i]), 32'd0);
            rst[i] = 1'b0;
            ena[i] = 1'b1;
        end

        // WS=0: basic write/read and address aliasing.
        xfer(0, 1'b1, 16'h0005, 16'h1234, 0);
        xfer(0, 1'b0, 16'h0005, 16'h0000, 0);
        xfer(0, 1'b1, 16'h0403, 16'hAAAA, 0);
        xfer(0, 1'b0, 16'h0003, 16'h0000, 0);

        // WS=0: strobe held high across two back-to-back reads.
        xfer(0, 1'b1, 16'h0001, 16'h0101, 0);
        xfer(0, 1'b1, 16'h0002, 16'h0202, 0);
        f_wre[0] = 1'b0;
        f_adr[0] = 16'h0001;
        f_stb[0] = 1'b1;
        wait_ack(0, 0, cyc);
        chk("b2b_first_lat", 0, cyc, 1);
        chk("b2b_first_data", 0, 32'(f_dti[0]), 32'(mdl[0][1]));
        f_adr[0] = 16'h0002;
        wait_ack(0, 0, cyc);
        chk("b2b_spacing", 0, cyc, 2);
        chk("b2b_second_data", 0, 32'(f_dti[0]), 32'(mdl[0][2]));
        last_rd[0] = mdl[0][2];
        f_stb[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_ack_width", 0, 32'(f_ack[0]), 32'd0);

        // WS=3: read takes four cycles.
        xfer(1, 1'b1, 16'h0010, 16'hBEEF, 0);
        xfer(1, 1'b0, 16'h0010, 16'h0000, 0);

        // WS=5: write aborted after two cycles must leave memory untouched.
        xfer(2, 1'b1, 16'h0020, 16'h1111, 0);
        f_wre[2] = 1'b1;
        f_adr[2] = 16'h0020;
        f_dto[2] = 16'h2222;
        f_stb[2] = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | f_ack[2];
        end
        f_stb[2] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | f_ack[2];
        end
        chk("abort_no_ack", 2, 32'(seen), 32'd0);
        xfer(2, 1'b0, 16'h0020, 16'h0000, 0);

        // WS=2: reset during WAIT cancels the write and clears f_dti.
        xfer(3, 1'b1, 16'h0030, 16'h5555, 0);
        xfer(3, 1'b0, 16'h0030, 16'h0000, 0);
        f_wre[3] = 1'b1;
        f_adr[3] = 16'h0030;
        f_dto[3] = 16'h6666;
        f_stb[3] = 1'b1;
        @(posedge clk);
        #1;
        rst[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("wait_rst_ack", 3, 32'(f_ack[3]), 32'd0);
        chk("wait_rst_dti", 3, 32'(f_dti[3]), 32'd0);
        last_rd[3] = 16'h0000;
        rst[3]   = 1'b0;
        f_stb[3] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | f_ack[3];
        end
        chk("wait_rst_no_ack", 3, 32'(seen), 32'd0);
        // Read back with ena low for 3 cycles mid-WAIT: latency 3 + 3.
        xfer(3, 1'b0, 16'h0030, 16'h0000, 3);

        // Random traffic: preload low addresses, then aliased random accesses.
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 16; a++) begin
                xfer(i, 1'b1, 16'(a), 16'($urandom), 0);
            end
            for (int n = 0; n < 20; n++) begin
                xfer(i, 1'($urandom_range(1, 0)), 16'($urandom) & 16'hFC0F,
                     16'($urandom), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcpu16_memslv.md
DCPU16_MEMSLV -- requirements
Module: dcpu16_memslv

Interface
REQ-001 The block SHALL have parameter AW, default 10, the word address width; the memory depth is 2^AW x 16 bits.
REQ-002 The block SHALL have parameter WS, default 0, range 0-15, the number of wait cycles inserted before f_ack.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port ena, input, 1, the clock enable; when low, all state, outputs and memory SHALL hold.
REQ-006 The block SHALL have port f_stb, input, 1, the request strobe from the bus master, held high until f_ack.
REQ-007 The block SHALL have port f_wre, input, 1, the write enable: 1 = write, 0 = read; sampled with f_stb.
REQ-008 The block SHALL have port f_adr, input, 16, the word address; only f_adr[AW-1:0] is used.
REQ-009 The block SHALL have port f_dto, input, 16, the write data from the master.
REQ-010 The block SHALL have port f_dti, output, 16, the read data to the master, registered.
REQ-011 The block SHALL have port f_ack, output, 1, the transfer acknowledge, registered, one cycle wide.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT and ACK; all transitions below occur only on cycles with ena=1.
REQ-013 In IDLE with f_stb=1, the FSM SHALL go to ACK if WS=0, else load the wait counter with WS-1 and go to WAIT.
REQ-014 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to ACK.
REQ-015 In WAIT with f_stb=0 (abort), the FSM SHALL return to IDLE, perform no write and raise no ack.
REQ-016 f_ack SHALL be 1 exactly during the ACK state; the ACK state SHALL always go to IDLE on the next cycle.
REQ-017 Latency SHALL be WS+1 cycles from the f_stb sampling edge to f_ack high.
REQ-018 Minimum spacing SHALL be 1 idle cycle after ACK; f_stb held high through ACK is taken as a new request in the following IDLE.
REQ-019 On a read, f_dti SHALL present mem[f_adr[AW-1:0]], valid in the f_ack cycle, and hold until the next read ack.
REQ-020 On a write, mem[f_adr[AW-1:0]] SHALL be written with f_dto on the clock edge that enters ACK; f_dti SHALL be unchanged.
REQ-021 f_adr, f_wre and f_dto SHALL be sampled at the edge entering ACK; the master holds them stable while f_stb=1.
REQ-022 Address bits f_adr[15:AW] SHALL be ignored, so addresses alias modulo 2^AW.
REQ-023 The wait counter SHALL be 4 bits wide and SHALL never underflow.
REQ-024 ena=0 in any state SHALL freeze the state, counter, f_ack level and f_dti; latency is counted in enabled cycles only.

Reset
REQ-025 On rst=1, the FSM SHALL go to IDLE, and f_ack, f_dti and the wait counter SHALL be 0, regardless of ena.
REQ-026 rst asserted in WAIT or ACK SHALL cancel the transfer; a write not yet committed SHALL not occur.
REQ-027 Memory contents SHALL not be cleared by reset, and rst SHALL take priority over f_stb.

Verification
REQ-028 WS=0, write 0x1234 to addr 0x0005, then read addr 0x0005 -> each f_ack high 1 cycle after f_stb, read f_dti=0x1234.
REQ-029 WS=3, read a preloaded addr 0x0010=0xBEEF -> f_ack high on the 4th cycle after f_stb, f_dti=0xBEEF, f_ack low next cycle.
REQ-030 AW=10, write 0xAAAA to 0x0403, read 0x0003 -> f_dti=0xAAAA (aliasing).
REQ-031 WS=5, write started, f_stb dropped after 2 cycles -> no f_ack, and a following read of that addr returns the old value.
REQ-032 WS=2, rst pulsed during WAIT of a write -> f_ack=0, f_dti=0, state IDLE, memory unchanged; ena=0 for 3 cycles mid-WAIT stretches latency by exactly 3.
REQ-033 f_stb held high for two back-to-back reads (0x0001 then 0x0002), WS=0 -> acks 2 cycles apart with the correct data each.
